// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4-source round-robin mux arbiter: FSM encoding,
// hold-counter width and the default preemption window.
package mux4_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    localparam int MAX_HOLD_DEFAULT = 8;
    localparam int CNT_W            = 8;

    typedef logic [CNT_W-1:0] hold_cnt_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ptr+3, ptr and
// returns the first requesting index.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux with bounded hold time and a
// one-cycle break-before-make gap between owners.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(MAX_HOLD - 1);

    logic [1:0] state;
    logic [1:0] ptr;
    hold_cnt_t  hold_cnt;
    logic [1:0] win;
    logic       any;
    logic       owner_req;
    logic       others_req;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // grant is one-hot while in GRANT, so masking with it isolates the owner.
    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= 4'b0000;
            sel      <= 2'd0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'd3;
        end else begin
            case (state)
                ST_GRANT: begin
                    if (!owner_req || (hold_cnt == HOLD_LAST && others_req)) begin
                        state <= ST_SWITCH;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and SWITCH both evaluate the requests the same way.
                    if (any) begin
                        state    <= ST_GRANT;
                        grant    <= onehot4(win);
                        sel      <= win;
                        ptr      <= win;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized checks of mux4_rr_arbiter with MAX_HOLD = 8.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD   = 8;
    // Worst pending time: own SWITCH cycle after preemption plus three full
    // owner turns of MAX_HOLD grant cycles and one SWITCH cycle each.
    localparam int WAIT_LIMIT = 3 * (MAX_HOLD + 1) + 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) r = 2'(k);
        end
        return r;
    endfunction

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_sel"},   32'(sel),   32'(s));
        check({tag, "_busy"},  32'(busy),  32'(b));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int         wait_c[4];
    int         max_wait;
    logic [1:0] last_sel;
    logic [3:0] e;
    logic [3:0] req_v;

    initial begin
        repeat (2) tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 4'b0000, 2'd0, 1'b0);

        // single requester, one-cycle latency
        req = 4'b0001;
        tick();
        expect_out("first_grant", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        expect_out("drop_switch", 4'b0000, 2'd0, 1'b0);
        tick();
        expect_out("drop_idle", 4'b0000, 2'd0, 1'b0);

        // full rotation with all sources requesting
        pulse_reset();
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < MAX_HOLD; c++) exp_q.push_back(4'b0001 << (o % 4));
            if (o < 4) exp_q.push_back(4'b0000);
        end
        last_sel = 2'd0;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            if (e != 4'b0000) last_sel = idx_of(e);
            expect_out("rotate", e, last_sel, e != 4'b0000);
        end
        req = 4'b0000;
        tick();
        expect_out("rotate_end", 4'b0000, 2'd0, 1'b0);
        tick();

        // owner 2 drops while source 0 waits
        req = 4'b0100;
        tick();
        expect_out("own2_a", 4'b0100, 2'd2, 1'b1);
        req = 4'b0101;
        tick();
        expect_out("own2_b", 4'b0100, 2'd2, 1'b1);
        tick();
        expect_out("own2_c", 4'b0100, 2'd2, 1'b1);
        req = 4'b0001;
        tick();
        expect_out("own2_switch", 4'b0000, 2'd2, 1'b0);
        tick();
        expect_out("own0_after", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // lone requester is never preempted
        req = 4'b0010;
        for (int i = 0; i < 50; i++) begin
            tick();
            expect_out("lone", 4'b0010, 2'd1, 1'b1);
        end
        req = 4'b0000;
        tick();
        expect_out("lone_release", 4'b0000, 2'd1, 1'b0);
        tick();

        // a pulse inside SWITCH that misses the sampling edge is ignored
        req = 4'b0001;
        tick();
        expect_out("pulse_own", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        expect_out("pulse_switch", 4'b0000, 2'd0, 1'b0);
        #1 req = 4'b1000;
        #2 req = 4'b0000;
        tick();
        expect_out("pulse_ignored", 4'b0000, 2'd0, 1'b0);
        tick();
        expect_out("pulse_idle", 4'b0000, 2'd0, 1'b0);

        // asynchronous reset in the middle of a grant
        req = 4'b0100;
        tick();
        expect_out("pre_rst", 4'b0100, 2'd2, 1'b1);
        tick();
        #2 rst_n = 1'b0;
        req = 4'b1000;
        #1 expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("post_rst", 4'b1000, 2'd3, 1'b1);

        // random traffic with invariant and starvation checks
        for (int k = 0; k < 4; k++) wait_c[k] = 0;
        max_wait = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            check("onehot", 32'($onehot0(grant)), 32'd1);
            check("busy_or", 32'(busy), 32'(|grant));
            if (busy) check("sel_idx", 32'(sel), 32'(idx_of(grant)));
            for (int k = 0; k < 4; k++) begin
                if (req[k] && !grant[k]) wait_c[k]++;
                else wait_c[k] = 0;
                if (wait_c[k] > max_wait) max_wait = wait_c[k];
            end
            req_v = req;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) req_v[k] = ~req_v[k];
            end
            req = req_v;
        end
        check("max_wait_ok", 32'(max_wait <= WAIT_LIMIT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
